imem_arbiter: RTL and testbench
===============================

# imem_arbiter

Sequencing and sharing controller for the single-port synchronous instruction memory of the pipelined RISC-V CPU. It arbitrates between the IF-stage fetch requester (reads) and the boot/program loader (writes). It holds the core in a BOOT phase until the loader signals the last word, then runs with fetch priority and a bounded-starvation guarantee for the loader. It also flags misaligned and out-of-range fetch addresses.

## Interface
- ADDR_W, 8: word-address width of the memory (2^ADDR_W words, default 256)
- STARVE_MAX, 4: cycles a pending loader request may wait in RUN before it overrides fetch (1..15)
- Clk  in  1  clock; all state updates on the rising edge
- Reset  in  1  asynchronous, active-high reset
- F_Req  in  1  fetch request; held with F_Addr until F_Gnt
- F_Addr  in  32  fetch byte address (PC)
- F_Gnt  out  1  fetch request accepted this cycle (combinational)
- F_Valid  out  1  F_Instr/F_Err valid; one cycle after F_Gnt
- F_Instr  out  32  fetched instruction; 0 when !F_Valid or F_Err
- F_Err  out  1  with F_Valid: F_Addr misaligned or out of range
- L_Req  in  1  loader write request; held with L_Addr/L_WData/L_Last until L_Gnt
- L_Addr  in  32  loader byte address
- L_WData  in  32  word to write
- L_Last  in  1  marks the final boot word
- L_Gnt  out  1  loader write accepted this cycle (combinational)
- Boot_Done  out  1  high in RUN state (core released)
- M_En  out  1  memory access strobe
- M_We  out  1  write enable (valid with M_En)
- M_Addr  out  ADDR_W  word address = granted address[ADDR_W+1:2]
- M_WData  out  32  write data = L_WData
- M_RData  in  32  read data, valid the cycle after a read strobe

## Operation
- States: BOOT (reset state), RUN. No other states; no return to BOOT except via Reset.
- BOOT: F_Gnt=0 always; L_Gnt=L_Req. A granted write with L_Last=1 moves to RUN next cycle.
- RUN: arbitration when both requests are pending:
  - If starve_cnt==STARVE_MAX, the loader wins.
  - Otherwise fetch wins.
  - A single pending requester always wins.
  - L_Last is ignored in RUN.
- starve_cnt (4 bits, RUN only):
  - +1 each cycle L_Req=1 and L_Gnt=0.
  - Cleared on L_Gnt or when L_Req=0.
  - Saturates at STARVE_MAX.
  - Held at 0 in BOOT.
- Granted loader write: M_En=1, M_We=1, M_Addr=L_Addr[ADDR_W+1:2], M_WData=L_WData. Misaligned or out-of-range loader addresses are written anyway using the truncated index; no error is reported.
- Granted fetch:
  - Bad address: F_Addr[1:0]!=0 or F_Addr[31:ADDR_W+2]!=0. M_En=0; the next cycle F_Valid=1, F_Err=1, F_Instr=0.
  - Good address: M_En=1, M_We=0, M_Addr=F_Addr[ADDR_W+1:2]. The next cycle F_Valid=1, F_Err=0, F_Instr=M_RData.
- At most one grant per cycle; M_En=0, M_We=0 when nothing is granted.
- Fetch may issue back-to-back (grant every cycle); F_Valid is a 1-cycle-delayed copy of F_Gnt.

## Timing
- Reset asserted, asynchronously: state=BOOT; starve_cnt=0; F_Valid=0; F_Err=0; F_Instr=0; Boot_Done=0. F_Gnt, L_Gnt, M_En and M_We are 0 while Reset is high.
- Reset mid-operation drops any in-flight read result: F_Valid is 0 the cycle after Reset, even if a grant occurred in the cycle Reset rose.
- Grants are combinational from the current-cycle requests and the registered state/starve_cnt. No grant-to-request loops: F_Req and L_Req must not depend on F_Gnt or L_Gnt.
- Read latency: F_Gnt in cycle N leads to F_Valid/F_Instr in cycle N+1.
- Write takes effect at the edge ending the L_Gnt cycle. A fetch granted in the next cycle to the same address returns the new word.
- BOOT→RUN: Boot_Done rises the cycle after the L_Last grant, and fetch may be granted in that same cycle.
- Loader worst-case wait in RUN under continuous fetch: STARVE_MAX cycles, with the grant in cycle STARVE_MAX+1 of the request.

## Test plan
- Reset then F_Req=1, F_Addr=0 in BOOT → F_Gnt=0 and Boot_Done=0 for 10 cycles; M_En=0.
- Loader writes 0x00100093 @0x0, 0x00208113 @0x4 (L_Last=1) → L_Gnt each cycle, M_We=1 with M_Addr=0 then 1. Boot_Done=1 the next cycle; then fetch 0x0 and 0x4 back-to-back → F_Valid on consecutive cycles with F_Instr=0x00100093, 0x00208113.
- RUN, F_Req held high continuously, L_Req raised at cycle T with STARVE_MAX=4 → L_Gnt=0 at T..T+3 and L_Gnt=1 at T+4 (fetch stalled that cycle). starve_cnt=0 afterward and fetch resumes at T+5.
- RUN fetch of 0x2 → F_Valid=1, F_Err=1, F_Instr=0, M_En=0. Fetch of 0x400 (ADDR_W=8) → F_Err=1. Fetch of 0x3FC → F_Err=0, reads word 255.
- Write 0xDEADBEEF @0x8 in cycle N, fetch 0x8 granted in N+1 → F_Instr=0xDEADBEEF in N+2.
- Assert Reset the cycle after a fetch grant in RUN → F_Valid=0 and state=BOOT, and fetch is not granted until a new L_Last write completes.

Source files
------------

// File: rtl/imem_arbiter_if.sv
// Request/response and memory-port bundle shared by the instruction-memory
// arbiter, the fetch requester, the boot loader and the memory itself.
interface imem_arbiter_if #(
    parameter int ADDR_W = 8
);
    logic              F_Req;
    logic [31:0]       F_Addr;
    logic              F_Gnt;
    logic              F_Valid;
    logic [31:0]       F_Instr;
    logic              F_Err;

    logic              L_Req;
    logic [31:0]       L_Addr;
    logic [31:0]       L_WData;
    logic              L_Last;
    logic              L_Gnt;

    logic              Boot_Done;

    logic              M_En;
    logic              M_We;
    logic [ADDR_W-1:0] M_Addr;
    logic [31:0]       M_WData;
    logic [31:0]       M_RData;

    modport slave (
        input  F_Req, F_Addr,
        input  L_Req, L_Addr, L_WData, L_Last,
        input  M_RData,
        output F_Gnt, F_Valid, F_Instr, F_Err,
        output L_Gnt, Boot_Done,
        output M_En, M_We, M_Addr, M_WData
    );

    modport master (
        output F_Req, F_Addr,
        output L_Req, L_Addr, L_WData, L_Last,
        output M_RData,
        input  F_Gnt, F_Valid, F_Instr, F_Err,
        input  L_Gnt, Boot_Done,
        input  M_En, M_We, M_Addr, M_WData
    );
endinterface

// File: rtl/imem_arbiter.sv
// Single-port instruction memory arbiter: boot-phase loader ownership, then
// fetch-priority sharing with a bounded wait for late loader writes.
module imem_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic          Clk,
    input  logic          Reset,
    imem_arbiter_if.slave bus
);
    typedef enum logic {
        S_BOOT,
        S_RUN
    } state_t;

    localparam logic [3:0] W_SMAX = 4'(STARVE_MAX);

    state_t     r_state;
    logic [3:0] r_starve;
    logic       r_fvalid;
    logic       r_ferr;

    logic       w_fbad;
    logic       w_fgnt;
    logic       w_lgnt;
    logic       w_starved;
    logic       w_unused;

    assign w_fbad = (bus.F_Addr[1:0] != 2'b00) ||
                    ((bus.F_Addr >> (ADDR_W + 2)) != 32'd0);

    assign w_starved = (r_starve == W_SMAX);

    // Loader's high address bits are dropped on purpose: writes wrap.
    assign w_unused = ^{bus.L_Addr[1:0], bus.L_Addr[31:ADDR_W+2]};

    always_comb begin
        w_lgnt = 1'b0;
        w_fgnt = 1'b0;
        if (!Reset) begin
            unique case (r_state)
                S_BOOT: begin
                    w_lgnt = bus.L_Req;
                end
                S_RUN: begin
                    w_lgnt = bus.L_Req && (!bus.F_Req || w_starved);
                    w_fgnt = bus.F_Req && !w_lgnt;
                end
                default: begin
                    w_lgnt = 1'b0;
                    w_fgnt = 1'b0;
                end
            endcase
        end
    end

    assign bus.F_Gnt     = w_fgnt;
    assign bus.L_Gnt     = w_lgnt;
    assign bus.M_En      = w_lgnt || (w_fgnt && !w_fbad);
    assign bus.M_We      = w_lgnt;
    assign bus.M_Addr    = w_lgnt ? bus.L_Addr[ADDR_W+1:2]
                                  : bus.F_Addr[ADDR_W+1:2];
    assign bus.M_WData   = bus.L_WData;

    assign bus.F_Valid   = r_fvalid;
    assign bus.F_Err     = r_ferr;
    assign bus.F_Instr   = (r_fvalid && !r_ferr) ? bus.M_RData : 32'd0;
    assign bus.Boot_Done = (r_state == S_RUN);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state  <= S_BOOT;
            r_starve <= 4'd0;
            r_fvalid <= 1'b0;
            r_ferr   <= 1'b0;
        end else begin
            r_fvalid <= w_fgnt;
            r_ferr   <= w_fgnt && w_fbad;
            unique case (r_state)
                S_BOOT: begin
                    r_starve <= 4'd0;
                    if (w_lgnt && bus.L_Last) begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (bus.L_Req && !w_lgnt) begin
                        r_starve <= w_starved ? r_starve : r_starve + 4'd1;
                    end else begin
                        r_starve <= 4'd0;
                    end
                end
                default: begin
                    r_state  <= S_BOOT;
                    r_starve <= 4'd0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_imem_arbiter.sv
// Randomised and directed bench for imem_arbiter against a behavioural
// model of grants, memory contents and read results.
module tb_imem_arbiter;
    localparam int AW    = 8;
    localparam int SMAX  = 4;
    localparam int DEPTH = 256;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    imem_arbiter_if #(.ADDR_W(AW)) bus ();

    imem_arbiter #(
        .ADDR_W    (AW),
        .STARVE_MAX(SMAX)
    ) dut (
        .Clk  (clk),
        .Reset(rst),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] env_mem [DEPTH];
    logic [31:0] ref_mem [DEPTH];

    // Memory environment: synchronous single port
    always @(posedge clk) begin
        if (bus.M_En) begin
            if (bus.M_We) env_mem[bus.M_Addr] <= bus.M_WData;
            else          bus.M_RData <= env_mem[bus.M_Addr];
        end
    end

    bit          m_run;
    int          m_wait;
    bit          m_pv;
    bit          m_pe;
    logic [31:0] m_pi;

    bit          s_fgnt, s_lgnt, s_fv, s_fe, s_bd, s_men, s_mwe;
    logic [31:0] s_fi;
    logic [AW-1:0] s_ma;

    function automatic logic [31:0] init_val(int i);
        return (32'(i) * 32'h9E3779B1) ^ 32'h13579BDF;
    endfunction

    function automatic bit addr_ok(logic [31:0] a);
        return (a % 4 == 0) && (a < DEPTH * 4);
    endfunction

    function automatic int widx(logic [31:0] a);
        return int'((a / 4) % DEPTH);
    endfunction

    function automatic logic [31:0] rand_addr();
        case ($urandom % 4)
            0, 1:    return {22'd0, 8'($urandom), 2'b00};
            2:       return {22'd0, 8'($urandom), 2'($urandom % 3 + 1)};
            default: return $urandom;
        endcase
    endfunction

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cycle();
        bit e_f, e_l, ok;
        @(negedge clk);
        s_fgnt = bus.F_Gnt;
        s_lgnt = bus.L_Gnt;
        s_fv   = bus.F_Valid;
        s_fe   = bus.F_Err;
        s_fi   = bus.F_Instr;
        s_bd   = bus.Boot_Done;
        s_men  = bus.M_En;
        s_mwe  = bus.M_We;
        s_ma   = bus.M_Addr;
        e_f = 1'b0;
        e_l = 1'b0;
        ok  = addr_ok(bus.F_Addr);
        if (!rst) begin
            if (!m_run) e_l = bus.L_Req;
            else if (bus.L_Req && (!bus.F_Req || m_wait >= SMAX)) e_l = 1'b1;
            else e_f = bus.F_Req;
        end
        check("f_gnt", s_fgnt, e_f);
        check("l_gnt", s_lgnt, e_l);
        check("m_en", s_men, e_l || (e_f && ok));
        check("m_we", s_mwe, e_l);
        if (e_l) begin
            check("m_addr_wr", s_ma, widx(bus.L_Addr));
            check("m_wdata", bus.M_WData, bus.L_WData);
        end else if (e_f && ok) begin
            check("m_addr_rd", s_ma, widx(bus.F_Addr));
        end
        check("boot_done", s_bd, !rst && m_run);
        check("f_valid", s_fv, !rst && m_pv);
        check("f_err", s_fe, !rst && m_pv && m_pe);
        check("f_instr", s_fi, (!rst && m_pv && !m_pe) ? m_pi : 32'd0);
        if (rst) begin
            m_run  = 1'b0;
            m_wait = 0;
            m_pv   = 1'b0;
        end else begin
            m_pv = e_f;
            m_pe = !ok;
            m_pi = ref_mem[widx(bus.F_Addr)];
            if (e_l) ref_mem[widx(bus.L_Addr)] = bus.L_WData;
            if (m_run && bus.L_Req && !e_l) m_wait++;
            else m_wait = 0;
            if (!m_run && e_l && bus.L_Last) m_run = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            env_mem[i] = init_val(i);
            ref_mem[i] = init_val(i);
        end
        m_run  = 1'b0;
        m_wait = 0;
        m_pv   = 1'b0;
        m_pe   = 1'b0;
        m_pi   = 32'd0;
        rst = 1'b1;
        bus.F_Req   = 1'b0;
        bus.F_Addr  = 32'd0;
        bus.L_Req   = 1'b0;
        bus.L_Addr  = 32'd0;
        bus.L_WData = 32'd0;
        bus.L_Last  = 1'b0;
        cycle();
        cycle();
        check("rst_fvalid", s_fv, 0);
        check("rst_bootdone", s_bd, 0);
        rst = 1'b0;

        // Fetch is held off while booting
        bus.F_Req = 1'b1;
        repeat (10) begin
            cycle();
            check("boot_no_fgnt", s_fgnt, 0);
            check("boot_not_done", s_bd, 0);
            check("boot_no_men", s_men, 0);
        end

        bus.F_Req   = 1'b0;
        bus.L_Req   = 1'b1;
        bus.L_Addr  = 32'h0;
        bus.L_WData = 32'h00100093;
        cycle();
        check("ld0_gnt", s_lgnt, 1);
        check("ld0_we", s_mwe, 1);
        check("ld0_addr", s_ma, 0);
        bus.L_Addr  = 32'h4;
        bus.L_WData = 32'h00208113;
        bus.L_Last  = 1'b1;
        cycle();
        check("ld1_gnt", s_lgnt, 1);
        check("ld1_addr", s_ma, 1);
        bus.L_Req  = 1'b0;
        bus.L_Last = 1'b0;
        bus.F_Req  = 1'b1;
        bus.F_Addr = 32'h0;
        cycle();
        check("run_done", s_bd, 1);
        check("run_fgnt", s_fgnt, 1);
        bus.F_Addr = 32'h4;
        cycle();
        check("rd0_valid", s_fv, 1);
        check("rd0_instr", s_fi, 32'h00100093);
        bus.F_Req = 1'b0;
        cycle();
        check("rd1_valid", s_fv, 1);
        check("rd1_instr", s_fi, 32'h00208113);

        // Bounded loader wait under continuous fetch
        bus.F_Req   = 1'b1;
        bus.F_Addr  = 32'h10;
        bus.L_Req   = 1'b1;
        bus.L_Addr  = 32'h20;
        bus.L_WData = 32'h12345678;
        for (int k = 0; k < SMAX; k++) begin
            cycle();
            check("starve_wait", s_lgnt, 0);
        end
        cycle();
        check("starve_lgnt", s_lgnt, 1);
        check("starve_fstall", s_fgnt, 0);
        bus.L_Req = 1'b0;
        cycle();
        check("starve_fresume", s_fgnt, 1);
        bus.L_Req = 1'b1;
        cycle();
        check("starve_cleared", s_lgnt, 0);
        bus.L_Req = 1'b0;
        bus.F_Req = 1'b0;
        cycle();

        // Address error handling
        bus.F_Req  = 1'b1;
        bus.F_Addr = 32'h2;
        cycle();
        check("mis_gnt", s_fgnt, 1);
        check("mis_men", s_men, 0);
        bus.F_Addr = 32'h400;
        cycle();
        check("mis_err", s_fe, 1);
        check("mis_instr", s_fi, 0);
        bus.F_Addr = 32'h3FC;
        cycle();
        check("oor_err", s_fe, 1);
        check("top_addr", s_ma, 255);
        bus.F_Req = 1'b0;
        cycle();
        check("top_err", s_fe, 0);
        check("top_instr", s_fi, init_val(255));

        // Write followed immediately by a read of the same word
        bus.L_Req   = 1'b1;
        bus.L_Addr  = 32'h8;
        bus.L_WData = 32'hDEADBEEF;
        cycle();
        check("wr_gnt", s_lgnt, 1);
        bus.L_Req  = 1'b0;
        bus.F_Req  = 1'b1;
        bus.F_Addr = 32'h8;
        cycle();
        check("raw_fgnt", s_fgnt, 1);
        bus.F_Req = 1'b0;
        cycle();
        check("raw_instr", s_fi, 32'hDEADBEEF);

        for (int i = 0; i < 3000; i++) begin
            cycle();
            if (!bus.F_Req || s_fgnt) begin
                bus.F_Req  = ($urandom % 4) != 0;
                bus.F_Addr = rand_addr();
            end
            if (!bus.L_Req || s_lgnt) begin
                bus.L_Req   = ($urandom % 3) == 0;
                bus.L_Addr  = ($urandom % 4 == 0) ? $urandom : rand_addr();
                bus.L_WData = $urandom;
                bus.L_Last  = 1'($urandom);
            end
        end
        bus.L_Req = 1'b0;
        bus.F_Req = 1'b0;
        cycle();

        // Reset in the middle of a read
        bus.F_Req  = 1'b1;
        bus.F_Addr = 32'hC;
        cycle();
        check("pre_rst_fgnt", s_fgnt, 1);
        rst = 1'b1;
        cycle();
        check("rst_drop_valid", s_fv, 0);
        check("rst_drop_done", s_bd, 0);
        rst = 1'b0;
        repeat (3) begin
            cycle();
            check("reboot_no_fgnt", s_fgnt, 0);
        end
        bus.L_Req   = 1'b1;
        bus.L_Addr  = 32'h0;
        bus.L_WData = 32'h00000013;
        bus.L_Last  = 1'b1;
        cycle();
        check("reboot_lgnt", s_lgnt, 1);
        check("reboot_fstall", s_fgnt, 0);
        bus.L_Req = 1'b0;
        cycle();
        check("reboot_fgnt", s_fgnt, 1);
        check("reboot_done", s_bd, 1);
        bus.F_Req = 1'b0;
        cycle();
        check("reboot_instr", s_fi, ref_mem[3]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
